// File: rtl/ram_dump_if.sv
// Chunk-request and payload-byte handshakes of the RAM dump engine.
// The master side issues chunk requests and payload bytes; the slave side acknowledges them.
interface ram_dump_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_offset;
  logic [15:0] req_len;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output req_valid,
    output req_offset,
    output req_len,
    output out_data,
    output out_valid,
    input  req_ready,
    input  out_ready
  );

  modport slave (
    input  req_valid,
    input  req_offset,
    input  req_len,
    input  out_data,
    input  out_valid,
    output req_ready,
    output out_ready
  );
endinterface

// File: rtl/ram_dump.sv
// Byte buffer that is filled while idle and then streamed out in CHUNK-sized requests.
// Each chunk is announced with an offset/length request, followed by its bytes one at a time.
module ram_dump #(
  parameter int DEPTH = 12288,
  parameter int CHUNK = 2048
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              fill_en,
  input  logic [13:0]       fill_addr,
  input  logic [7:0]        fill_data,
  ram_dump_if.master        dump,
  output logic              busy,
  output logic              done
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int IW = (CHUNK > 1) ? $clog2(CHUNK) : 1;
  localparam logic [14:0]   DEPTH_W  = 15'(DEPTH);
  localparam logic [14:0]   CHUNK_W  = 15'(CHUNK);
  localparam logic [IW-1:0] IDX_LAST = IW'(CHUNK - 1);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    FETCH,
    SEND,
    NEXT,
    DONE
  } state_t;

  state_t        state_reg, state_next;
  logic [13:0]   offset_reg, offset_next;
  logic [IW-1:0] idx_reg, idx_next;

  logic [7:0]    mem [DEPTH];
  logic [7:0]    rd_data_reg;
  logic [13:0]   rd_addr;
  logic          rd_en;
  logic          fill_ok;
  logic          last_chunk;

  // The buffer is frozen during a dump so the stream is a consistent snapshot.
  assign fill_ok    = fill_en && (state_reg == IDLE) && ({1'b0, fill_addr} < DEPTH_W);
  assign rd_addr    = offset_reg + 14'(idx_reg);
  assign rd_en      = (state_reg == FETCH);
  assign last_chunk = (({1'b0, offset_reg} + CHUNK_W) == DEPTH_W);

  always_ff @(posedge clk) begin
    if (fill_ok) begin
      mem[fill_addr[AW-1:0]] <= fill_data;
    end
  end

  // Read data is captured only in FETCH, so it stays put for the whole SEND stall.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data_reg <= mem[rd_addr[AW-1:0]];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      offset_reg <= '0;
      idx_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      offset_reg <= offset_next;
      idx_reg    <= idx_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    offset_next = offset_reg;
    idx_next    = idx_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          offset_next = '0;
          idx_next    = '0;
          state_next  = REQ;
        end
      end
      REQ: begin
        if (dump.req_ready) begin
          state_next = FETCH;
        end
      end
      FETCH: begin
        state_next = SEND;
      end
      SEND: begin
        if (dump.out_ready) begin
          if (idx_reg == IDX_LAST) begin
            state_next = NEXT;
          end else begin
            idx_next   = idx_reg + 1'b1;
            state_next = FETCH;
          end
        end
      end
      NEXT: begin
        if (last_chunk) begin
          state_next = DONE;
        end else begin
          offset_next = offset_reg + CHUNK_W[13:0];
          idx_next    = '0;
          state_next  = REQ;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // All outputs decode the state register directly, so reset clears them without a clock.
  assign dump.req_valid  = (state_reg == REQ);
  assign dump.req_offset = {18'd0, offset_reg};
  assign dump.req_len    = 16'(CHUNK);
  assign dump.out_valid  = (state_reg == SEND);
  assign dump.out_data   = (state_reg == SEND) ? rd_data_reg : 8'h00;
  assign busy            = (state_reg != IDLE);
  assign done            = (state_reg == DONE);

endmodule

// File: doc/ram_dump.md
RAM_DUMP -- requirements
Module: ram_dump

Interface
REQ-001 Parameter DEPTH, default 12288, buffer size in bytes (multiple of CHUNK, at most 16384).
REQ-002 Parameter CHUNK, default 2048, bytes per write request (power of two, at most DEPTH).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  one-cycle pulse that begins a dump of the whole buffer.
REQ-006 fill_en  input  1  buffer write strobe.
REQ-007 fill_addr  input  14  buffer byte address.
REQ-008 fill_data  input  8  buffer write data.
REQ-009 req_valid  output  1  "fwrite" chunk request valid.
REQ-010 req_ready  input  1  chunk request accepted.
REQ-011 req_offset  output  32  file byte offset of the current chunk.
REQ-012 req_len  output  16  chunk length in bytes, constant CHUNK.
REQ-013 out_data  output  8  payload byte.
REQ-014 out_valid  output  1  payload byte valid.
REQ-015 out_ready  input  1  payload byte accepted.
REQ-016 busy  output  1  dump in progress (state not IDLE).
REQ-017 done  output  1  one-cycle pulse when the last byte has been accepted.

Function
REQ-018 Storage: DEPTH x 8 synchronous RAM with one write port (fill) and one read port (dump); read data is available one cycle after the address is presented.
REQ-019 Fill writes: taken only in IDLE and only when fill_addr < DEPTH; all other fill writes are ignored.
REQ-020 FSM states: IDLE, REQ, FETCH, SEND, NEXT, DONE.
REQ-021 IDLE -> REQ on start; req_offset <= 0, byte counters cleared.
REQ-022 start outside IDLE is ignored.
REQ-023 REQ: req_valid = 1; req_offset and req_len held stable until the cycle req_valid && req_ready; then -> FETCH.
REQ-024 FETCH: drive read address = req_offset + chunk byte index; -> SEND next cycle.
REQ-025 SEND: out_valid = 1; out_data = RAM read data latched on entry, held stable until out_valid && out_ready.
REQ-026 On a SEND handshake: if chunk index == CHUNK-1 -> NEXT, otherwise increment the index and -> FETCH.
REQ-027 Throughput: one byte per two cycles at most; out_valid is deasserted during FETCH.
REQ-028 NEXT: if req_offset + CHUNK == DEPTH -> DONE; otherwise req_offset <= req_offset + CHUNK, index cleared, -> REQ.
REQ-029 req_offset is zero-extended to 32 bits and never exceeds DEPTH - CHUNK.
REQ-030 DONE: done = 1 for exactly one cycle, then -> IDLE.
REQ-031 req_valid and out_valid are never asserted in the same cycle.
REQ-032 A sustained out_ready = 0 stalls SEND indefinitely with no loss or duplication; a sustained req_ready = 0 likewise stalls REQ.
REQ-033 Handshake signals on req/out are ignored in states that do not drive the matching valid.

Reset
REQ-034 rst asserted at any time, including mid-chunk: state <= IDLE immediately (asynchronous).
REQ-035 Reset values: req_valid = 0, out_valid = 0, done = 0, busy = 0, req_offset = 0, out_data = 0, counters = 0.
REQ-036 Buffer contents need not be cleared by reset.
REQ-037 After rst deasserts, the block waits in IDLE for start; there is no automatic restart.

Verification
REQ-038 Fill bytes addr[7:0] at addresses 0..12287; pulse start; req_ready and out_ready held 1 -> 6 requests with offsets 0x0, 0x800, ... 0x2800 and req_len 0x800; 12288 out bytes in address order; exactly one done pulse.
REQ-039 Hold req_ready = 0 for 20 cycles in REQ -> req_valid and req_offset stay stable, no out_valid; accepted on the first req_ready cycle.
REQ-040 Random out_ready backpressure, 50% duty -> byte sequence identical to the no-stall case; out_data stable while out_valid && !out_ready.
REQ-041 fill_en pulsed while busy at addr 5 with data 0xAA -> readback in the next dump still returns the original byte; start pulsed mid-dump -> no restart and offsets unchanged.
REQ-042 Assert rst during chunk 3 at byte 100 -> busy, req_valid and out_valid fall asynchronously; a new start then yields first offset 0 and first byte = buffer[0].
REQ-043 DEPTH = CHUNK = 2048 -> a single request at offset 0, then done after byte 2047.
